// File: rtl/hs_dpath_pipe_ctrl.sv
// hs_dpath_pipe_ctrl: valid/ready sequencer for a fixed-latency datapath.
// Optional bubble collapse: define HS_DPATH_PIPE_CTRL_BUBBLE_COLLAPSE_EN.
module hs_dpath_pipe_ctrl #(
  parameter int LATENCY = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LATENCY-1:0]           stage_ce,
  input  logic                         flush_req,
  output logic                         flush_done,
  output logic [$clog2(LATENCY+1)-1:0] occupancy,
  output logic                         busy
);

  localparam int OW = $clog2(LATENCY+1);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state;
  state_t state_next;
  logic done_next;
  logic drain_end;

  logic [LATENCY-1:0] vld;
  logic [LATENCY-1:0] vld_shift;
  logic [LATENCY-1:0] ce_raw;
  logic advance;
  logic in_fire;
  logic out_fire;

  assign advance   = ~vld[LATENCY-1] | out_ready;
  assign out_valid = vld[LATENCY-1];
  assign out_fire  = out_valid & out_ready;
  assign in_fire   = in_valid & in_ready;

`ifdef HS_DPATH_PIPE_CTRL_BUBBLE_COLLAPSE_EN
  // A stage may load when it is empty or its successor is loading.
  always_comb begin
    logic c;
    ce_raw = '0;
    c = advance;
    for (int k = LATENCY-1; k >= 0; k--) begin
      if (k < LATENCY-1) c = ~vld[k] | c;
      ce_raw[k] = c;
    end
  end
`else
  // Global stall: every stage moves together.
  always_comb begin
    ce_raw = {LATENCY{advance}};
  end
`endif

  // Reset forces all enables on and blocks intake.
  always_comb begin
    stage_ce = reset ? '1 : ce_raw;
    in_ready = ~reset & ce_raw[0] & (state == RUN);
  end

  assign vld_shift = (vld << 1) | LATENCY'(in_fire);

  // Enabled stages take their predecessor's valid bit; others hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
    end else begin
      vld <= (stage_ce & vld_shift) | (~stage_ce & vld);
    end
  end

  // Items in flight: +1 on intake only, -1 on exit only.
  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy <= '0;
    end else if (in_fire && !out_fire) begin
      occupancy <= occupancy + OW'(1);
    end else if (out_fire && !in_fire) begin
      occupancy <= occupancy - OW'(1);
    end
  end

  assign drain_end = (occupancy == '0) ||
                     ((occupancy == OW'(1)) && out_fire);

  // Next state: flush request drains, last exit returns to RUN.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      RUN: begin
        if (flush_req) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_end) begin
          state_next = RUN;
          done_next  = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // State register and registered drain-complete pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      flush_done <= 1'b0;
    end else begin
      state      <= state_next;
      flush_done <= done_next;
    end
  end

  assign busy = (occupancy != '0) || (state == DRAIN);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !((occupancy == OW'(LATENCY)) && in_fire && !out_fire));

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !((occupancy == '0) && out_fire && !in_fire));

endmodule

// File: tb/tb_hs_dpath_pipe_ctrl.sv
// tb_hs_dpath_pipe_ctrl: directed tests for hs_dpath_pipe_ctrl, LATENCY=3.
// Covers streaming, stall, back-to-back, flush and reset-in-drain.
module tb_hs_dpath_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] stage_ce;
  logic       flush_req = 1'b0;
  logic       flush_done;
  logic [1:0] occupancy;
  logic       busy;

  int errors = 0;
  int checks = 0;

  hs_dpath_pipe_ctrl #(.LATENCY(3)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .stage_ce(stage_ce),
    .flush_req(flush_req),
    .flush_done(flush_done),
    .occupancy(occupancy),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush_req = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    in_valid = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    checks++;
    if (stage_ce !== 3'b111) begin
      errors++;
      $display("FAIL reset_stage_ce: got %b want 111", stage_ce);
    end
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: out_valid=%b busy=%b want 0 0", out_valid, busy);
    end
    checks++;
    if (occupancy !== 2'd0 || flush_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_occ: occ=%0d done=%b want 0 0", occupancy, flush_done);
    end
  endtask

  task automatic test_stream();
    logic [1:0] occ_exp [10];
    logic       ov_exp;
    occ_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      in_valid = (c <= 4);
      out_ready = 1'b1;
      ov_exp = (c >= 3) && (c <= 7);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_in_ready c%0d: got %b want 1", c, in_ready);
      end
      checks++;
      if (out_valid !== ov_exp) begin
        errors++;
        $display("FAIL stream_out_valid c%0d: got %b want %b", c, out_valid, ov_exp);
      end
      checks++;
      if (occupancy !== occ_exp[c]) begin
        errors++;
        $display("FAIL stream_occ c%0d: got %0d want %0d", c, occupancy, occ_exp[c]);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stall_fill c%0d: in_ready got %b want 1", c, in_ready);
      end
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (stage_ce !== 3'b000 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ce c%0d: ce=%b rdy=%b want 000 0", c, stage_ce, in_ready);
      end
      checks++;
      if (occupancy !== 2'd3 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold c%0d: occ=%0d ov=%b want 3 1", c, occupancy, out_valid);
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: occ=%0d ov=%b want 0 0", occupancy, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    tick();
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_fire: rdy=%b ov=%b want 1 1", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (occupancy !== 2'd3 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_occ: occ=%0d ov=%b want 3 1", occupancy, out_valid);
    end
    n = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid === 1'b1) n++;
      tick();
    end
    checks++;
    if (n !== 3 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL b2b_items: outs=%0d occ=%0d want 3 0", n, occupancy);
    end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    flush_req = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || occupancy !== 2'd2) begin
      errors++;
      $display("FAIL flush_start: rdy=%b occ=%0d want 1 2", in_ready, occupancy);
    end
    tick();
    flush_req = 1'b0;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_d0: rdy=%b ov=%b busy=%b want 0 1 1", in_ready, out_valid, busy);
    end
    tick();
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || occupancy !== 2'd1 || flush_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_d1: rdy=%b ov=%b occ=%0d done=%b want 0 1 1 0",
               in_ready, out_valid, occupancy, flush_done);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (flush_done !== 1'b1 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_done: done=%b rdy=%b occ=%0d ov=%b want 1 1 0 0",
               flush_done, in_ready, occupancy, out_valid);
    end
    tick();
    #1;
    checks++;
    if (flush_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: done=%b busy=%b want 0 0", flush_done, busy);
    end
  endtask

  task automatic test_flush_empty();
    do_reset();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || flush_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty_drain: rdy=%b busy=%b done=%b want 0 1 0",
               in_ready, busy, flush_done);
    end
    tick();
    #1;
    checks++;
    if (flush_done !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty_done: done=%b rdy=%b busy=%b want 1 1 0",
               flush_done, in_ready, busy);
    end
  endtask

  task automatic test_flush_priority();
    do_reset();
    in_valid = 1'b1;
    flush_req = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL prio_accept: rdy=%b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    flush_req = 1'b0;
    #1;
    checks++;
    if (occupancy !== 2'd1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_drain: occ=%0d rdy=%b want 1 0", occupancy, in_ready);
    end
    tick();
    tick();
    #1;
    checks++;
    if (out_valid !== 1'b1 || flush_done !== 1'b0) begin
      errors++;
      $display("FAIL prio_out: ov=%b done=%b want 1 0", out_valid, flush_done);
    end
    tick();
    #1;
    checks++;
    if (flush_done !== 1'b1 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL prio_done: done=%b occ=%0d want 1 0", flush_done, occupancy);
    end
  endtask

  task automatic test_reset_drain();
    do_reset();
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (occupancy !== 2'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rstd_pre: occ=%0d busy=%b want 2 1", occupancy, busy);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || flush_done !== 1'b0) begin
      errors++;
      $display("FAIL rstd_post: occ=%0d ov=%b done=%b want 0 0 0",
               occupancy, out_valid, flush_done);
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstd_run: rdy=%b busy=%b want 1 0", in_ready, busy);
    end
    tick();
    #1;
    checks++;
    if (flush_done !== 1'b0) begin
      errors++;
      $display("FAIL rstd_nodone: done=%b want 0", flush_done);
    end
  endtask

  task automatic test_bubble();
    logic [2:0] ce3_exp;
    logic [2:0] ce4_exp;
`ifdef HS_DPATH_PIPE_CTRL_BUBBLE_COLLAPSE_EN
    ce3_exp = 3'b011;
    ce4_exp = 3'b001;
`else
    ce3_exp = 3'b000;
    ce4_exp = 3'b000;
`endif
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (stage_ce !== ce3_exp || occupancy !== 2'd2) begin
      errors++;
      $display("FAIL bubble_ce: ce=%b occ=%0d want %b 2", stage_ce, occupancy, ce3_exp);
    end
    tick();
    #1;
    checks++;
    if (stage_ce !== ce4_exp || out_valid !== 1'b1 || occupancy !== 2'd2) begin
      errors++;
      $display("FAIL bubble_moved: ce=%b ov=%b occ=%0d want %b 1 2",
               stage_ce, out_valid, occupancy, ce4_exp);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (occupancy !== 2'd0) begin
      errors++;
      $display("FAIL bubble_drain: occ=%0d want 0", occupancy);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_flush();
    test_flush_empty();
    test_flush_priority();
    test_reset_drain();
    test_bubble();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hs_dpath_pipe_ctrl.md
HS_DPATH_PIPE_CTRL -- requirements
Module: hs_dpath_pipe_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 3, meaning the number of datapath register stages sequenced, legal range 1..64.
REQ-002 SHALL have input clk, width 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have input reset, width 1; reset is synchronous and active-high.
REQ-004 SHALL have input in_valid, width 1, meaning an upstream item is offered.
REQ-005 SHALL have output in_ready, width 1, meaning the item is accepted this cycle when in_valid is also high.
REQ-006 SHALL have output out_valid, width 1, meaning the last stage holds a valid item.
REQ-007 SHALL have input out_ready, width 1, meaning downstream accepts the item this cycle.
REQ-008 SHALL have output stage_ce, LATENCY bits, where bit i is the clock enable of datapath stage i+1.
REQ-009 SHALL have input flush_req, width 1, a level request to stop intake and drain.
REQ-010 SHALL have output flush_done, width 1, a one-cycle pulse when a drain completes.
REQ-011 SHALL have output occupancy, $clog2(LATENCY+1) bits, giving the count of valid items in flight.
REQ-012 SHALL have output busy, width 1, high when occupancy is nonzero or the state is DRAIN.

Function
REQ-013 SHALL keep an internal valid vector vld[1..LATENCY]; out_valid = vld[LATENCY].
REQ-014 SHALL define out_fire = out_valid & out_ready and in_fire = in_valid & in_ready.
REQ-015 SHALL, in global-stall mode, drive every stage_ce bit = advance, where advance = ~vld[LATENCY] | out_ready.
REQ-016 SHALL, when stage k is enabled, load vld[1] with in_fire and vld[k] with vld[k-1] for k>1; disabled stages hold their value.
REQ-017 SHALL provide a latency of exactly LATENCY cycles with no stalls: an item accepted in cycle t gives out_valid in cycle t+LATENCY.
REQ-018 SHALL drive in_ready = stage_ce[0] & (state == RUN); the path is combinational from out_ready.
REQ-019 SHALL drop an item offered while in_ready is low; in_valid is never latched.
REQ-020 SHALL update occupancy as follows: +1 on in_fire only, -1 on out_fire only, unchanged on both or neither.
REQ-021 SHALL never let occupancy exceed LATENCY or underflow below 0; either event is a design error that an assertion flags.
REQ-022 SHALL use FSM state RUN, which accepts input; flush_req high moves the FSM to DRAIN on the next edge.
REQ-023 SHALL use FSM state DRAIN, with in_ready = 0 and the pipeline still advancing per REQ-015.
REQ-024 SHALL, when in DRAIN with occupancy == 0, or occupancy == 1 with out_fire, pulse flush_done in the next cycle and return to RUN.
REQ-025 SHALL treat flush_req asserted in RUN with occupancy 0 as DRAIN for one cycle, then flush_done, then RUN.
REQ-026 SHALL ignore flush_req while in DRAIN; flush_req still high after return to RUN re-enters DRAIN.
REQ-027 SHALL give flush_req priority over in_valid in the same cycle in RUN: that item is still accepted (in_ready is already evaluated), and the drain includes it.

Reset
REQ-028 SHALL, when reset is high at a clock edge, clear vld to 0, set occupancy to 0 and state to RUN, and drive flush_done to 0.
REQ-029 SHALL drive in_ready = 0 and stage_ce all 1 while reset is high; out_valid = 0 and busy = 0 the cycle after.
REQ-030 SHALL discard in-flight items on reset mid-operation or mid-drain, with no flush_done pulse.

Configuration
REQ-031 SHALL select bubble collapse with macro HS_DPATH_PIPE_CTRL_BUBBLE_COLLAPSE_EN.
REQ-032 SHALL, when the macro is defined, drive stage_ce[LATENCY-1] = advance and stage_ce[k-1] = ~vld[k] | stage_ce[k] for k < LATENCY, so empty stages fill while the output is stalled.
REQ-033 SHALL, when the macro is undefined, use global stall per REQ-015; latency with no stalls is identical in both builds.

Verification
REQ-034 SHALL test LATENCY=3 with out_ready=1 and in_valid high for cycles 0-4: out_valid in cycles 3-7, occupancy reaches 3, in_ready always 1.
REQ-035 SHALL test LATENCY=3 with the pipe full and out_ready=0 for 5 cycles: stage_ce all 0, in_ready 0, occupancy stays 3, output held stable.
REQ-036 SHALL test bubble collapse (macro on) with items at stages 1 and 3, out_ready=0: the stage-1 item moves to stage 2 and stage_ce = 3'b011.
REQ-037 SHALL test flush_req pulsed with occupancy 2 and out_ready=1: in_ready 0, the 2 items exit, then flush_done pulses once and the FSM returns to RUN.
REQ-038 SHALL test reset asserted in DRAIN with occupancy 2: the next cycle shows occupancy 0, out_valid 0, state RUN, and no flush_done.
REQ-039 SHALL test in_fire and out_fire in the same cycle at occupancy 3: occupancy stays 3 and no item is lost.
